// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI register bank slave.
// Read-back on spi_miso is enabled by SPI_REGBANK_READBACK_EN.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_t;

  localparam int MIN_OVERSAMPLE = 8;

  function automatic int cmd_bits(int addr_w);
    return 1 + addr_w;
  endfunction

  // Bit counter must span both the command and a data word.
  function automatic int cnt_w(int data_w, int addr_w);
    int m;
    m = (data_w > cmd_bits(addr_w)) ? data_w : cmd_bits(addr_w);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser with rise/fall strobes.
// Used for each of the asynchronous SPI inputs.
module spi_sync_edge (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave exposing a bank of parameterised registers.
// Read-back on spi_miso is enabled by SPI_REGBANK_READBACK_EN.
module spi_regbank_slave
  import spi_regbank_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_cs,
  input  logic                       spi_sclk,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_stb_o,
  output logic                       err_o
);

  localparam int CNT_W = cnt_w(DATA_W, ADDR_W);
  localparam int CMD_W = cmd_bits(ADDR_W);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge u_cs (
    .clk (clk),
    .d   (spi_cs),
    .q   (cs_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  spi_sync_edge u_sclk (
    .clk (clk),
    .d   (spi_sclk),
    .q   (sclk_s),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge u_mosi (
    .clk (clk),
    .d   (spi_mosi),
    .q   (mosi_s),
    .rise(mosi_rise),
    .fall(mosi_fall)
  );

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CMD_W-1:0]     cmd_sr;
  logic [DATA_W-1:0]    data_sr;
  logic [IDX_W-1:0]     idx;
  logic                 rd;
  logic [DATA_W-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_stb;
  logic                 err;

  logic [CMD_W-1:0]     cmd_next;
  logic [DATA_W-1:0]    data_next;
  logic                 addr_ok;
  logic [IDX_W-1:0]     a_idx;
  logic [IDX_W-1:0]     idx_inc;
  logic                 cmd_last;
  logic                 data_last;

  assign cmd_next  = {cmd_sr[CMD_W-2:0], mosi_s};
  assign data_next = {data_sr[DATA_W-2:0], mosi_s};
  assign addr_ok   = 32'(cmd_next[ADDR_W-1:0]) < NUM_REGS;
  assign a_idx     = cmd_next[IDX_W-1:0];
  assign idx_inc   = (idx == IDX_W'(NUM_REGS - 1)) ? '0 : idx + 1'b1;
  assign cmd_last  = bit_cnt == CNT_W'(ADDR_W);
  assign data_last = bit_cnt == CNT_W'(DATA_W - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      data_sr <= '0;
      idx     <= '0;
      rd      <= 1'b0;
      wr_stb  <= '0;
      err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RST_VALS[i*DATA_W +: DATA_W];
    end else begin
      wr_stb <= '0;
      err    <= 1'b0;
      if (cs_rise) begin
        // A partially shifted command or word is an abort.
        if ((state == CMD || state == DATA) && bit_cnt != '0)
          err <= 1'b1;
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_next;
              if (cmd_last) begin
                bit_cnt <= '0;
                if (addr_ok) begin
                  state <= DATA;
                  idx   <= a_idx;
                  rd    <= cmd_next[ADDR_W];
                end else begin
                  err   <= 1'b1;
                  state <= WAIT_CS;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              data_sr <= data_next;
              if (data_last) begin
                bit_cnt <= '0;
                idx     <= idx_inc;
                if (!rd) begin
                  regs[idx]   <= data_next;
                  wr_stb[idx] <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WAIT_CS: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

  assign wr_stb_o = wr_stb;
  assign err_o    = err;

`ifdef SPI_REGBANK_READBACK_EN
  logic [DATA_W-1:0] sout;
  logic              miso_r;

  // The fall right after a load must not shift, so the MSB is
  // held until the master samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sout   <= '0;
      miso_r <= 1'b0;
    end else begin
      if (!cs_rise && state == CMD && sclk_rise && cmd_last && addr_ok)
        sout <= regs[a_idx];
      else if (!cs_rise && state == DATA && sclk_rise && data_last)
        sout <= regs[idx_inc];
      else if (!cs_rise && state == DATA && sclk_fall && bit_cnt != '0)
        sout <= {sout[DATA_W-2:0], 1'b0};
      miso_r <= 1'b0;
    end
  end

  assign spi_miso = ~cs_s & rd & (state == DATA) & sout[DATA_W-1];

  logic unused_ok;
  assign unused_ok = ^{sclk_s, mosi_rise, mosi_fall, miso_r};
`else
  assign spi_miso = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{cs_s, sclk_s, sclk_fall, mosi_rise, mosi_fall};
`endif

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave (16 x 32 bit, 7-bit addr).
// Read-back expectations follow SPI_REGBANK_READBACK_EN.
module tb_spi_regbank_slave;
  import spi_regbank_pkg::*;

  localparam int NR   = 16;
  localparam int DW   = 32;
  localparam int HALF = MIN_OVERSAMPLE;

  function automatic logic [NR*DW-1:0] mk_rv();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++)
      v[i*DW +: DW] = 32'hA500_0000 + 32'(i * 3);
    return v;
  endfunction

  localparam logic [NR*DW-1:0] RV = mk_rv();

  logic clk = 0;
  logic rst, spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_stb_o;
  logic             err_o;

  spi_regbank_slave #(
    .NUM_REGS(NR),
    .DATA_W  (DW),
    .ADDR_W  (7),
    .RST_VALS(RV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .spi_cs  (spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .regs_o  (regs_o),
    .wr_stb_o(wr_stb_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int err_cyc = 0;
  int stb_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (err_o) err_cyc++;
      for (int i = 0; i < NR; i++)
        if (wr_stb_o[i]) stb_q.push_back(i);
    end
  end

  task automatic chk(input string tag,
                     input logic [NR*DW-1:0] got,
                     input logic [NR*DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    err_cyc = 0;
    stb_q.delete();
  endtask

  task automatic shift(input logic [63:0] v, input int n,
                       output logic [63:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      wclk(HALF);
      got[i] = spi_miso;
      spi_sclk = 1'b1;
      wclk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic rw, input logic [6:0] a,
                       input logic [63:0] d, input int n,
                       output logic [63:0] got);
    logic [63:0] dummy;
    spi_cs = 1'b0;
    wclk(HALF);
    shift({56'h0, rw, a}, 8, dummy);
    shift(d, n, got);
    wclk(HALF);
    spi_cs = 1'b1;
    wclk(4 * HALF);
  endtask

  function automatic int stb_at(int k);
    return (stb_q.size() > k) ? stb_q[k] : -1;
  endfunction

  logic [NR*DW-1:0] exp_img;
  logic [63:0]      got;
  logic [31:0]      exp_rd;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    wclk(10);
    chk("rst_img", regs_o, RV);
    chk("rst_stb", wr_stb_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_miso", spi_miso, 0);
    rst = 1'b0;
    wclk(10);
    exp_img = RV;

    clr();
    frame(1'b0, 7'h05, 64'hDEAD_BEEF, 32, got);
    exp_img[5*DW +: DW] = 32'hDEAD_BEEF;
    chk("w5_word", regs_o[5*DW +: DW], 32'hDEAD_BEEF);
    chk("w5_img", regs_o, exp_img);
    chk("w5_nstb", stb_q.size(), 1);
    chk("w5_stb", stb_at(0), 5);
    chk("w5_err", err_cyc, 0);

    clr();
    frame(1'b0, 7'h0F, 64'h1111_1111_2222_2222, 64, got);
    exp_img[15*DW +: DW] = 32'h1111_1111;
    exp_img[0 +: DW]     = 32'h2222_2222;
    chk("bu_w15", regs_o[15*DW +: DW], 32'h1111_1111);
    chk("bu_w0", regs_o[0 +: DW], 32'h2222_2222);
    chk("bu_img", regs_o, exp_img);
    chk("bu_nstb", stb_q.size(), 2);
    chk("bu_stb0", stb_at(0), 15);
    chk("bu_stb1", stb_at(1), 0);
    chk("bu_err", err_cyc, 0);

    clr();
    frame(1'b1, 7'h05, 64'h0, 32, got);
`ifdef SPI_REGBANK_READBACK_EN
    exp_rd = 32'hDEAD_BEEF;
`else
    exp_rd = 32'h0;
`endif
    chk("rd5_miso", got[31:0], exp_rd);
    chk("rd5_img", regs_o, exp_img);
    chk("rd5_nstb", stb_q.size(), 0);
    chk("rd5_err", err_cyc, 0);

    clr();
    frame(1'b0, 7'h20, 64'hCAFE_F00D, 32, got);
    chk("oor_err", err_cyc, 1);
    chk("oor_img", regs_o, exp_img);
    chk("oor_nstb", stb_q.size(), 0);

    clr();
    frame(1'b0, 7'h03, 64'hABCDE, 20, got);
    chk("abt_w3", regs_o[3*DW +: DW], RV[3*DW +: DW]);
    chk("abt_err", err_cyc, 1);
    chk("abt_nstb", stb_q.size(), 0);

    clr();
    spi_cs = 1'b0;
    wclk(HALF);
    shift(64'h06, 8, got);
    shift(64'h155, 10, got);
    rst = 1'b1;
    wclk(5);
    rst = 1'b0;
    shift(64'h1F, 5, got);
    wclk(HALF);
    spi_cs = 1'b1;
    wclk(4 * HALF);
    chk("mrst_img", regs_o, RV);
    chk("mrst_err", err_cyc, 0);
    chk("mrst_nstb", stb_q.size(), 0);

    clr();
    exp_img = RV;
    frame(1'b0, 7'h06, 64'h1234_5678, 32, got);
    exp_img[6*DW +: DW] = 32'h1234_5678;
    chk("post_w6", regs_o[6*DW +: DW], 32'h1234_5678);
    chk("post_img", regs_o, exp_img);
    chk("post_nstb", stb_q.size(), 1);
    chk("post_stb", stb_at(0), 6);
    chk("post_err", err_cyc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_regbank_slave.md
SPI_REGBANK_SLAVE -- requirements
Module: spi_regbank_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of user registers, range 2..256.
REQ-002 SHALL have parameter DATA_W, default 32: register width in bits, range 8..64.
REQ-003 SHALL have parameter ADDR_W, default 7: frame address field width; 2**ADDR_W >= NUM_REGS.
REQ-004 SHALL have parameter RST_VALS, default all-zero: NUM_REGS*DATA_W reset image, with register i at bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have port clk  in  1: single system clock.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port spi_cs  in  1: chip select, active low, asynchronous to clk.
REQ-008 SHALL have port spi_sclk  in  1: SPI clock, mode 0, asynchronous to clk.
REQ-009 SHALL have port spi_mosi  in  1: master-out data, MSB first.
REQ-010 SHALL have port spi_miso  out  1: slave-out data, driven 0 when idle; no tristate.
REQ-011 SHALL have port regs_o  out  NUM_REGS*DATA_W: flat register image.
REQ-012 SHALL have port wr_stb_o  out  NUM_REGS: one-clk pulse on the register just written.
REQ-013 SHALL have port err_o  out  1: one-clk pulse on an out-of-range access or an aborted frame.

Function
REQ-014 SHALL pass spi_cs, spi_sclk and spi_mosi through 3-flop synchronisers; all frame logic SHALL use the synchronised signals and SCLK rise/fall edge strobes. clk SHALL run at >= 8x SCLK.
REQ-015 SHALL decode a frame as 1 R/W bit (1 = read), then ADDR_W address bits, then one or more DATA_W data words, all MSB first and sampled on SCLK rising edges.
REQ-016 SHALL use the FSM states IDLE, CMD, DATA and WAIT_CS. CS falling edge moves IDLE to CMD. The (1+ADDR_W)th bit moves CMD to DATA. CS rising edge from any state returns to IDLE.
REQ-017 SHALL commit a write the clk cycle after the sampling edge of the last data bit: regs_o word updated and wr_stb_o bit high for exactly 1 clk in that cycle.
REQ-018 SHALL support burst access: after each complete DATA_W word with CS still low, the address increments by 1 and wraps from NUM_REGS-1 to 0.
REQ-019 SHALL handle an address >= NUM_REGS (including the initial address) as follows: no write, no wr_stb_o, err_o pulse, read data all-zero; the FSM moves to WAIT_CS until CS rises.
REQ-020 SHALL handle CS rising mid-word as an abort: the partial word is discarded, no register changes, err_o pulses once, and the FSM returns to IDLE.
REQ-021 SHALL, when reads and writes are simultaneous (read of a register whose write commits in the same clk), return the pre-write value.
REQ-022 SHALL ignore SCLK edges while CS is high; spi_miso SHALL be 0 whenever synchronised CS is high.

Reset
REQ-023 SHALL, while rst is high, load regs_o from RST_VALS, drive wr_stb_o=0, err_o=0 and spi_miso=0, set FSM=IDLE and clear bit/address counters.
REQ-024 SHALL, on reset asserted mid-frame, abandon the frame silently with no err_o; the next frame SHALL start only on a fresh CS falling edge after reset.

Configuration
REQ-025 SHALL use macro SPI_REGBANK_READBACK_EN to control read-back. When defined, during DATA of a read frame the addressed word is loaded at DATA entry (and at each burst increment) and shifted out on spi_miso, changing on SCLK falling edges, MSB first.
REQ-026 SHALL, when SPI_REGBANK_READBACK_EN is undefined, tie spi_miso to 0 and treat read frames as no-ops (no write, no err_o unless out-of-range or aborted).

Structure
REQ-027 SHALL place the FSM state enum, frame field width helpers and the minimum-oversample constant in package spi_regbank_pkg.
REQ-028 SHALL instantiate one sub-module, spi_sync_edge (3-flop synchroniser plus rise/fall strobes), three times.

Verification
REQ-029 SHALL verify, with NUM_REGS=16, DATA_W=32, ADDR_W=7: write addr 0x05, data 0xDEADBEEF -> regs_o word 5 = 0xDEADBEEF and a single wr_stb_o[5] pulse.
REQ-030 SHALL verify a burst write at addr 0x0F of 0x11111111 then 0x22222222 -> word15=0x11111111, word0=0x22222222, and two strobes in order 15 then 0.
REQ-031 SHALL verify, with SPI_REGBANK_READBACK_EN defined, read of addr 0x05 after REQ-029 -> spi_miso returns 0xDEADBEEF MSB first; with the macro undefined, spi_miso stays 0.
REQ-032 SHALL verify write to addr 0x20 -> err_o one pulse, regs_o unchanged, wr_stb_o stays 0.
REQ-033 SHALL verify CS raised after 20 data bits of a write to addr 0x03 -> word 3 unchanged and err_o one pulse.
REQ-034 SHALL verify rst asserted mid-frame -> regs_o=RST_VALS, no err_o, and the next full frame is accepted correctly.
